turfio_cin_autolock: RTL

Parametrised successor to the CIN parallel-sync stage. Runs in the aclk domain, downstream of the rxclk->aclk transfer. Assembles NIB_WIDTH-bit beats into WORD_WIDTH-bit commands and finds word alignment itself: it bit-slips across all offsets against a training pattern, verifies the match, then monitors bit errors and loss of lock. Feeds command_o/command_valid_o and the ctrlstat registers.

---
 rtl/turfio_cin_pkg.sv | 19 +
 rtl/turfio_cin_word_assembler.sv | 66 ++++++
 rtl/turfio_cin_autolock.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/turfio_cin_pkg.sv
// Shared types and helpers for the CIN word-alignment stage.
package turfio_cin_pkg;

  typedef enum logic [1:0] {IDLE, SEARCH, VERIFY, LOCKED} cin_lock_state_t;

  localparam int unsigned POPCOUNT_MAX_W = 256;

  function automatic int unsigned calc_beats(input int unsigned nib_w, input int unsigned word_w);
    return word_w / nib_w;
  endfunction

  function automatic int unsigned popcount(input logic [POPCOUNT_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POPCOUNT_MAX_W; i++) n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/turfio_cin_word_assembler.sv
// Builds WORD_WIDTH-bit words from NIB_WIDTH-bit beats at a selectable bit offset,
// suppressing the first word strobe after each offset slip.
module turfio_cin_word_assembler
  import turfio_cin_pkg::*;
#(
  parameter int unsigned NIB_WIDTH  = 4,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NIB_WIDTH-1:0]          cin_i,
  input  logic                          cin_valid_i,
  input  logic [$clog2(WORD_WIDTH)-1:0] offset_i,
  input  logic                          slip_i,
  output logic [WORD_WIDTH-1:0]         word_o,
  output logic                          word_valid_o
);

  localparam int unsigned BEATS  = calc_beats(NIB_WIDTH, WORD_WIDTH);
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned HIST_W = 2 * WORD_WIDTH;

  logic [HIST_W-1:0]     hist_q, hist_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic                  word_valid_q, word_valid_d;
  logic                  holdoff_q, holdoff_d;
  logic                  last_beat;

  always_comb begin
    hist_d    = hist_q;
    cnt_d     = cnt_q;
    last_beat = 1'b0;
    if (cin_valid_i) begin
      hist_d    = {hist_q[HIST_W-NIB_WIDTH-1:0], cin_i};
      last_beat = (cnt_q == CNT_W'(BEATS - 1));
      cnt_d     = last_beat ? '0 : cnt_q + 1'b1;
    end
    // Word is cut from the post-shift history so it appears one cycle after the final beat.
    word_d       = last_beat ? hist_d[offset_i +: WORD_WIDTH] : word_q;
    word_valid_d = last_beat && !holdoff_q;
    if (slip_i)         holdoff_d = 1'b1;
    else if (last_beat) holdoff_d = 1'b0;
    else                holdoff_d = holdoff_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q       <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      holdoff_q    <= 1'b0;
    end else begin
      hist_q       <= hist_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      holdoff_q    <= holdoff_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

endmodule

// File: rtl/turfio_cin_autolock.sv
// CIN parallel-sync stage with automatic bit-slip alignment against a training word,
// lock verification, bit-error accounting and loss-of-lock detection.
module turfio_cin_autolock
  import turfio_cin_pkg::*;
#(
  parameter int unsigned           NIB_WIDTH     = 4,
  parameter int unsigned           WORD_WIDTH    = 32,
  parameter logic [WORD_WIDTH-1:0] TRAIN_PATTERN = 32'hA55A6996,
  parameter int unsigned           LOCK_COUNT    = 4,
  parameter int unsigned           ERR_LIMIT     = 4,
  parameter int unsigned           ERRCNT_WIDTH  = 16,
  parameter int unsigned           AUTO_RELOCK   = 0
) (
  input  logic                          aclk_i,
  input  logic                          rst_i,
  input  logic [NIB_WIDTH-1:0]          cin_i,
  input  logic                          cin_valid_i,
  input  logic                          lock_req_i,
  input  logic                          lock_rst_i,
  input  logic                          bitslip_i,
  input  logic                          train_i,
  input  logic                          biterr_clr_i,
  output logic [WORD_WIDTH-1:0]         cin_parallel_o,
  output logic                          cin_parallel_valid_o,
  output logic                          locked_o,
  output logic                          lock_fail_o,
  output logic                          unlock_o,
  output logic [$clog2(WORD_WIDTH)-1:0] offset_o,
  output logic [ERRCNT_WIDTH-1:0]       biterr_count_o
);

  localparam int unsigned OFF_W    = $clog2(WORD_WIDTH);
  localparam int unsigned TRY_W    = OFF_W + 1;
  localparam int unsigned MATCH_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned CONSEC_W = $clog2(ERR_LIMIT + 1);
  localparam int unsigned SUM_W    = ERRCNT_WIDTH + 1;

  cin_lock_state_t       state_q, state_d;
  logic [OFF_W-1:0]      offset_q, offset_d, start_off_q, start_off_d;
  logic [TRY_W-1:0]      tries_q, tries_d, tries_inc;
  logic [MATCH_W-1:0]    matches_q, matches_d, matches_inc;
  logic [CONSEC_W-1:0]   consec_q, consec_d, consec_inc;
  logic                  lock_fail_q, lock_fail_d, unlock_q, unlock_d;
  logic [ERRCNT_WIDTH-1:0] errcnt_q, errcnt_d, errcnt_base;
  logic [SUM_W-1:0]      err_sum;
  logic [WORD_WIDTH-1:0] word;
  logic                  word_valid, is_match, slip, search_miss;

  turfio_cin_word_assembler #(
    .NIB_WIDTH (NIB_WIDTH),
    .WORD_WIDTH(WORD_WIDTH)
  ) u_asm (
    .clk_i       (aclk_i),
    .rst_i       (rst_i),
    .cin_i       (cin_i),
    .cin_valid_i (cin_valid_i),
    .offset_i    (offset_q),
    .slip_i      (slip),
    .word_o      (word),
    .word_valid_o(word_valid)
  );

  assign is_match    = (word == TRAIN_PATTERN);
  assign tries_inc   = tries_q + 1'b1;
  assign matches_inc = matches_q + 1'b1;
  assign consec_inc  = consec_q + 1'b1;
  assign errcnt_base = biterr_clr_i ? '0 : errcnt_q;
  assign err_sum     = {1'b0, errcnt_base}
                     + SUM_W'(popcount(POPCOUNT_MAX_W'(word ^ TRAIN_PATTERN)));

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    start_off_d = start_off_q;
    tries_d     = tries_q;
    matches_d   = matches_q;
    consec_d    = consec_q;
    lock_fail_d = lock_fail_q;
    unlock_d    = 1'b0;
    slip        = 1'b0;
    search_miss = 1'b0;
    errcnt_d    = errcnt_base;

    if (state_q == LOCKED && word_valid && train_i)
      errcnt_d = err_sum[ERRCNT_WIDTH] ? '1 : err_sum[ERRCNT_WIDTH-1:0];

    if (lock_rst_i) begin
      state_d     = IDLE;
      lock_fail_d = 1'b0;
      tries_d     = '0;
      matches_d   = '0;
      consec_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (lock_req_i) begin
            state_d     = SEARCH;
            lock_fail_d = 1'b0;
            tries_d     = '0;
            matches_d   = '0;
            start_off_d = offset_q;
          end else if (bitslip_i) begin
            slip = 1'b1;
          end
        end
        SEARCH: begin
          if (word_valid) begin
            if (is_match) begin
              matches_d = MATCH_W'(1);
              state_d   = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
            end else begin
              search_miss = 1'b1;
            end
          end
        end
        VERIFY: begin
          if (word_valid) begin
            if (is_match) begin
              matches_d = matches_inc;
              if (matches_inc == MATCH_W'(LOCK_COUNT)) state_d = LOCKED;
            end else begin
              search_miss = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (!train_i) begin
            consec_d = '0;
          end else if (word_valid) begin
            if (is_match) begin
              consec_d = '0;
            end else if (consec_inc == CONSEC_W'(ERR_LIMIT)) begin
              consec_d  = '0;
              unlock_d  = 1'b1;
              matches_d = '0;
              tries_d   = '0;
              if (AUTO_RELOCK != 0) begin
                state_d     = SEARCH;
                start_off_d = offset_q;
              end else begin
                state_d = IDLE;
              end
            end else begin
              consec_d = consec_inc;
            end
          end
        end
      endcase

      // Shared SEARCH/VERIFY miss path: slip, or give up and restore the starting offset.
      if (search_miss) begin
        matches_d = '0;
        if (tries_inc == TRY_W'(WORD_WIDTH)) begin
          state_d     = IDLE;
          lock_fail_d = 1'b1;
          offset_d    = start_off_q;
          tries_d     = '0;
        end else begin
          slip    = 1'b1;
          tries_d = tries_inc;
          state_d = SEARCH;
        end
      end
    end

    if (slip) offset_d = (offset_q == OFF_W'(WORD_WIDTH - 1)) ? '0 : offset_q + 1'b1;
  end

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      offset_q    <= '0;
      start_off_q <= '0;
      tries_q     <= '0;
      matches_q   <= '0;
      consec_q    <= '0;
      lock_fail_q <= 1'b0;
      unlock_q    <= 1'b0;
      errcnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      start_off_q <= start_off_d;
      tries_q     <= tries_d;
      matches_q   <= matches_d;
      consec_q    <= consec_d;
      lock_fail_q <= lock_fail_d;
      unlock_q    <= unlock_d;
      errcnt_q    <= errcnt_d;
    end
  end

  assign locked_o             = (state_q == LOCKED);
  assign cin_parallel_o       = word;
  assign cin_parallel_valid_o = word_valid && (state_q == LOCKED);
  assign lock_fail_o          = lock_fail_q;
  assign unlock_o             = unlock_q;
  assign offset_o             = offset_q;
  assign biterr_count_o       = errcnt_q;

endmodule
